// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if -- instruction-memory request/response bundle.
//
// Signals:
//   imem_read     fetch -> memory  read request, held while a fetch is open
//   imem_address  fetch -> memory  32-bit fetch address
//   imem_rdata    memory -> fetch  instruction word, valid with imem_resp
//   imem_resp     memory -> fetch  one-cycle completion pulse
//
// Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface if_fetch_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_rdata,
    output imem_resp
  );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage with one-entry skid buffer and
// branch/jump redirect handling.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   imem         if_fetch_if.master: read/address out, rdata/resp in
//   stall        IF/ID register is not loading this cycle
//   redirect     resolved branch/jump: squash and change PC
//   redirect_pc  target PC, sampled with redirect (no alignment check)
//   ir_out       fetched instruction (NOP_INSN when not valid)
//   pc_out       PC of ir_out
//   valid_out    qualifies ir_out/pc_out; IF/ID load
//
// At most one memory request is in flight. A fetch that returns while the
// output slot is blocked parks in the skid buffer (WAIT_OUT, no new request).
// A redirect without a response has to wait for the open request to finish
// (FLUSH), whose data is then thrown away.
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000060,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  if_fetch_if.master        imem,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       ir_out,
  output logic [31:0]       pc_out,
  output logic              valid_out
);

  typedef enum logic [1:0] {
    S_REQ      = 2'd0,
    S_WAIT_OUT = 2'd1,
    S_FLUSH    = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] skid_ir_reg;
  logic [31:0] skid_pc_reg;
  logic [31:0] pend_pc_reg;
  logic        imem_read_reg;
  logic [31:0] ir_reg;
  logic [31:0] pc_out_reg;
  logic        valid_reg;

  // A response only counts while we actually have a request open; this
  // drops stray pulses in the first cycle after reset release.
  logic resp_ok;
  logic slot_free;
  logic slot_taken;

  assign resp_ok    = imem.imem_resp & imem_read_reg;
  assign slot_free  = ~valid_reg | ~stall;
  assign slot_taken = valid_reg & ~stall;

  assign imem.imem_read    = imem_read_reg;
  assign imem.imem_address = pc_reg;
  assign ir_out            = ir_reg;
  assign pc_out            = pc_out_reg;
  assign valid_out         = valid_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_REQ;
      pc_reg        <= RESET_PC;
      skid_ir_reg   <= 32'd0;
      skid_pc_reg   <= 32'd0;
      pend_pc_reg   <= 32'd0;
      imem_read_reg <= 1'b0;
      ir_reg        <= NOP_INSN;
      pc_out_reg    <= 32'd0;
      valid_reg     <= 1'b0;
    end else begin
      imem_read_reg <= 1'b1;
      // Default slot behaviour: an accepted word with no replacement empties.
      if (slot_taken) begin
        valid_reg <= 1'b0;
        ir_reg    <= NOP_INSN;
      end

      if (redirect) begin
        // Squash whatever is in the slot, independent of stall.
        valid_reg <= 1'b0;
        ir_reg    <= NOP_INSN;
      end

      case (state_reg)
        S_REQ: begin
          if (redirect) begin
            if (resp_ok) begin
              pc_reg <= redirect_pc;
            end else begin
              pend_pc_reg <= redirect_pc;
              state_reg   <= S_FLUSH;
            end
          end else if (resp_ok) begin
            pc_reg <= pc_reg + 32'd4;
            if (slot_free) begin
              ir_reg     <= imem.imem_rdata;
              pc_out_reg <= pc_reg;
              valid_reg  <= 1'b1;
            end else begin
              skid_ir_reg   <= imem.imem_rdata;
              skid_pc_reg   <= pc_reg;
              state_reg     <= S_WAIT_OUT;
              imem_read_reg <= 1'b0;
            end
          end
        end

        S_WAIT_OUT: begin
          if (redirect) begin
            pc_reg    <= redirect_pc;
            state_reg <= S_REQ;
          end else if (!stall) begin
            ir_reg     <= skid_ir_reg;
            pc_out_reg <= skid_pc_reg;
            valid_reg  <= 1'b1;
            state_reg  <= S_REQ;
          end else begin
            imem_read_reg <= 1'b0;
          end
        end

        S_FLUSH: begin
          // Address stays at the old PC until the open request drains.
          if (resp_ok) begin
            pc_reg    <= redirect ? redirect_pc : pend_pc_reg;
            state_reg <= S_REQ;
          end else if (redirect) begin
            pend_pc_reg <= redirect_pc;
          end
        end

        default: begin
          state_reg <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000060, SHALL be the PC of the first fetch after reset.
REQ-002 Parameter NOP_INSN, default 32'h00000013, SHALL be the value driven on ir_out when no valid instruction is held.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 imem_read  output  1  SHALL be the instruction-memory read request.
REQ-006 imem_address  output  32  SHALL be the fetch address, driven from the internal PC register.
REQ-007 imem_rdata  input  32  SHALL be the instruction word, valid only when imem_resp=1.
REQ-008 imem_resp  input  1  SHALL be the one-cycle memory completion pulse.
REQ-009 stall  input  1  SHALL indicate that the downstream IF/ID register is not loading this cycle.
REQ-010 redirect  input  1  SHALL request a PC change or squash from a resolved branch or jump.
REQ-011 redirect_pc  input  32  SHALL be the target PC, sampled when redirect=1.
REQ-012 ir_out  output  32  SHALL carry the fetched instruction to the IF/ID ir_in port.
REQ-013 pc_out  output  32  SHALL carry the PC of ir_out to the IF/ID pc_in port.
REQ-014 valid_out  output  1  SHALL qualify ir_out and pc_out, and SHALL drive IF/ID load.

Function
REQ-015 Output slot: {ir_out, pc_out, valid_out} SHALL be registered; it is accepted in any cycle with valid_out=1 and stall=0.
REQ-016 The FSM SHALL have exactly three states: REQ, WAIT_OUT and FLUSH.
REQ-017 REQ state: imem_read=1 and imem_address=pc.
- The address SHALL stay stable until imem_resp.
REQ-018 REQ state, imem_resp=1, redirect=0, slot free (valid_out=0 or stall=0):
- load slot with {imem_rdata, pc, 1}
- pc<=pc+4
- remain in REQ
REQ-019 REQ state, imem_resp=1, redirect=0, slot full and stall=1:
- store {imem_rdata, pc} in the skid buffer
- pc<=pc+4
- go to WAIT_OUT
REQ-020 WAIT_OUT state: imem_read=0.
- When stall=0, load the slot from the skid buffer and go to REQ.
REQ-021 REQ state, redirect=1 and imem_resp=1:
- discard imem_rdata
- pc<=redirect_pc
- remain in REQ
REQ-022 REQ state, redirect=1 and imem_resp=0:
- latch redirect_pc into a pending-target register
- go to FLUSH
REQ-023 FLUSH state: imem_read=1 at the unchanged old address.
- On imem_resp: discard the data, set pc<=pending target, go to REQ.
- A redirect during FLUSH SHALL overwrite the pending target.
- A redirect coinciding with imem_resp in FLUSH SHALL use the new redirect_pc.
REQ-024 WAIT_OUT state, redirect=1: discard the skid buffer, pc<=redirect_pc, go to REQ.
REQ-025 Any redirect SHALL clear valid_out on the next edge regardless of stall; redirect has priority over every other event.
REQ-026 When valid_out=0, ir_out SHALL equal NOP_INSN.
REQ-027 An accepted slot with no new load SHALL clear valid_out on the next edge.
REQ-028 PC increment SHALL be modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000.
REQ-029 redirect_pc SHALL be used as-is, with no alignment check.
REQ-030 Latency: an instruction SHALL appear on valid_out the edge after its imem_resp, except through the WAIT_OUT path.
REQ-031 At most one memory request SHALL be outstanding; no instruction SHALL be duplicated or dropped except by squash.

Reset
REQ-032 While rst=0, regardless of clk:
- imem_read=0
- valid_out=0
- ir_out=NOP_INSN
- pc_out=0
- pc=RESET_PC
- state=REQ
- skid buffer and pending target cleared
REQ-033 On the first edge after rst rises, imem_read=1 with imem_address=RESET_PC.
REQ-034 Reset asserted mid-request SHALL abandon the request.
- Any imem_resp in the same cycle as, or after, reset assertion SHALL be ignored.

Verification
REQ-035 Streaming: resp every cycle with stall=0 -> addresses 0x60,0x64,0x68 in order; valid_out pc_out sequence 0x60,0x64,0x68, each with its rdata.
REQ-036 Stall: stall=1 while the slot holds 0x60 and resp arrives for 0x64 -> WAIT_OUT with imem_read=0; after stall=0, slot shows 0x60 then 0x64, then fetch resumes at 0x68.
REQ-037 Redirect during an outstanding request (no resp), target 0x200 -> address holds 0x64 until resp; that data is discarded; next address is 0x200; valid_out=0 for the squashed word.
REQ-038 Redirect coinciding with resp, and redirect in WAIT_OUT, target 0x300 -> no stale word reaches valid_out; next fetch address is 0x300.
REQ-039 Wrap: redirect to 0xFFFFFFFC, resp -> pc_out=0xFFFFFFFC, next address 0x00000000.
REQ-040 Async reset pulse mid-request, with a resp in the reset cycle -> outputs go to reset values immediately; the first post-reset address is 0x60; the ignored resp never appears on valid_out.
